// File: rtl/fp16_minmax_reduce_pkg.sv
// fp16_minmax_reduce_pkg: FP16 type, field positions, canonical quiet NaN and reduce FSM states
package fp16_minmax_reduce_pkg;
  typedef logic [15:0] fp16_t;
  localparam int EMSB = 14;
  localparam int FMSB = 9;
  localparam fp16_t FP16_QNAN = 16'h7E00;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/fp16_minmax_reduce_order_key.sv
// fp16_order_key: data -> unsigned-comparable ordering key, is_nan, is_snan (combinational)
module fp16_order_key
  import fp16_minmax_reduce_pkg::*;
(
  input  fp16_t       data,
  output logic [15:0] key,
  output logic        is_nan,
  output logic        is_snan
);
  assign is_nan  = (&data[EMSB:FMSB+1]) && (|data[FMSB:0]);
  assign is_snan = is_nan && !data[FMSB];
  assign key     = data[15] ? ~data : data ^ 16'h8000;
endmodule

// File: rtl/fp16_minmax_reduce.sv
// fp16_minmax_reduce: streams FP16 beats (in_valid/in_ready/in_data/in_last), reports min/max/count/NaN flags (out_valid/out_ready)
module fp16_minmax_reduce
  import fp16_minmax_reduce_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  fp16_t              in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output fp16_t              out_min,
  output fp16_t              out_max,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_nan,
  output logic               out_snan,
  output logic               out_allnan
);
  state_t state, state_n;
  logic [15:0] key, min_key, max_key;
  logic is_nan, is_snan, seen, nan_r, snan_r, acc, clr;
  fp16_t min_r, max_r;
  logic [COUNT_W-1:0] count;
  fp16_order_key u_key (.data(in_data), .key(key), .is_nan(is_nan), .is_snan(is_snan));
  assign in_ready   = state != HOLD;
  assign out_valid  = state == HOLD;
  assign acc        = in_valid && in_ready;
  assign clr        = out_valid && out_ready;
  assign out_min    = (out_valid && !seen) ? FP16_QNAN : min_r;
  assign out_max    = (out_valid && !seen) ? FP16_QNAN : max_r;
  assign out_allnan = out_valid && !seen;
  assign out_count  = count;
  assign out_nan    = nan_r;
  assign out_snan   = snan_r;
  always_comb begin
    state_n = state;
    state_n = (state == HOLD) ? (out_ready ? IDLE : HOLD) : acc ? (in_last ? HOLD : ACCUM) : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      count   <= '0;
      nan_r   <= 1'b0;
      snan_r  <= 1'b0;
      seen    <= 1'b0;
      min_r   <= '0;
      max_r   <= '0;
      min_key <= '0;
      max_key <= '0;
    end else if (acc) begin
      count  <= count + COUNT_W'(count != '1);
      nan_r  <= nan_r | is_nan;
      snan_r <= snan_r | is_snan;
      if (!is_nan) begin
        seen <= 1'b1;
        if (!seen || key < min_key) begin
          min_r   <= in_data;
          min_key <= key;
        end
        if (!seen || key > max_key) begin
          max_r   <= in_data;
          max_key <= key;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp16_minmax_reduce.sv
// tb_fp16_minmax_reduce: randomized and directed checks of fp16_minmax_reduce against a real-valued ordering model
module tb_fp16_minmax_reduce;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid, out_nan, out_snan, out_allnan;
  logic [15:0] out_min, out_max;
  logic [7:0] out_count;
  logic in_ready2, out_valid2, out_nan2, out_snan2, out_allnan2;
  logic [15:0] out_min2, out_max2;
  logic [1:0] out_count2;
  int checks = 0, errors = 0;
  logic [15:0] pkt[$];
  logic [15:0] e_min, e_max;
  int e_n;
  bit e_nan, e_snan, e_all;

  fp16_minmax_reduce dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
    .out_count(out_count), .out_nan(out_nan), .out_snan(out_snan), .out_allnan(out_allnan));
  fp16_minmax_reduce #(.COUNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_min(out_min2),
    .out_max(out_max2), .out_count(out_count2), .out_nan(out_nan2), .out_snan(out_snan2), .out_allnan(out_allnan2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic bit fp_isnan(input logic [15:0] h);
    return h[14:10] == 5'h1f && h[9:0] != 0;
  endfunction

  function automatic real fp_val(input logic [15:0] h);
    int e;
    real f, m;
    e = int'(h[14:10]);
    f = real'(h[9:0]);
    if (e == 0) m = f / 1024.0 * (2.0 ** (-14));
    else if (e == 31) m = 1.0e9;
    else m = (1.0 + f / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -m : m;
  endfunction

  function automatic bit fp_less(input logic [15:0] a, input logic [15:0] b);
    real va, vb;
    va = fp_val(a);
    vb = fp_val(b);
    return va < vb || (va == vb && a[15] && !b[15]);
  endfunction

  task automatic model();
    e_n = pkt.size();
    e_nan = 0;
    e_snan = 0;
    e_all = 1;
    e_min = 16'h7E00;
    e_max = 16'h7E00;
    foreach (pkt[i]) begin
      if (fp_isnan(pkt[i])) begin
        e_nan = 1;
        if (!pkt[i][9]) e_snan = 1;
      end else if (e_all) begin
        e_min = pkt[i];
        e_max = pkt[i];
        e_all = 0;
      end else begin
        if (fp_less(pkt[i], e_min)) e_min = pkt[i];
        if (fp_less(e_max, pkt[i])) e_max = pkt[i];
      end
    end
  endtask

  task automatic run_packet(input string tag, input int stall, input int gap);
    logic [7:0] ec;
    logic [1:0] ec2;
    bit last;
    model();
    ec = e_n > 255 ? 8'd255 : 8'(e_n);
    ec2 = e_n > 3 ? 2'd3 : 2'(e_n);
    foreach (pkt[i]) begin
      for (int g = 0; g < gap && i > 0; g++) begin
        in_data = 16'($urandom);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s idle_gap: out_valid=%b in_ready=%b, need 0/1", tag, out_valid, in_ready);
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready beat %0d: got %b need 1", tag, i, in_ready);
      end
      last = (i == pkt.size() - 1);
      in_valid = 1;
      in_data = pkt[i];
      in_last = last;
      @(posedge clk); #1;
      in_valid = 0;
      in_last = 0;
      checks++;
      if (out_valid !== last) begin
        errors++;
        $display("FAIL %s out_valid after beat %0d: got %b need %b", tag, i, out_valid, last);
      end
    end
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== e_min || out_max !== e_max || out_count !== ec ||
          out_nan !== e_nan || out_snan !== e_snan || out_allnan !== e_all) begin
        errors++;
        $display("FAIL %s result cyc%0d: v=%b rdy=%b min=%h max=%h cnt=%0d nan=%b snan=%b all=%b; need v=1 rdy=0 min=%h max=%h cnt=%0d nan=%b snan=%b all=%b",
          tag, s, out_valid, in_ready, out_min, out_max, out_count, out_nan, out_snan, out_allnan,
          e_min, e_max, ec, e_nan, e_snan, e_all);
      end
      checks++;
      if (out_valid2 !== 1'b1 || out_count2 !== ec2 || out_min2 !== e_min || out_max2 !== e_max ||
          out_nan2 !== e_nan || out_snan2 !== e_snan || out_allnan2 !== e_all || in_ready2 !== 1'b0) begin
        errors++;
        $display("FAIL %s narrow result cyc%0d: v=%b cnt=%0d min=%h max=%h; need v=1 cnt=%0d min=%h max=%h",
          tag, s, out_valid2, out_count2, out_min2, out_max2, ec2, e_min, e_max);
      end
      if (s < stall) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0 || out_nan !== 1'b0 || out_allnan !== 1'b0) begin
      errors++;
      $display("FAIL %s after handshake: v=%b rdy=%b cnt=%0d nan=%b all=%b; need 0 1 0 0 0",
        tag, out_valid, in_ready, out_count, out_nan, out_allnan);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || out_min !== 0 || out_max !== 0 || out_count !== 0 || out_nan !== 0 || out_snan !== 0 || out_allnan !== 0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b min=%h max=%h cnt=%0d nan=%b snan=%b all=%b; need all 0",
        out_valid, out_min, out_max, out_count, out_nan, out_snan, out_allnan);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    pkt = '{16'h3C00, 16'hC000, 16'h4200};
    run_packet("basic", 0, 0);
    pkt = '{16'h8000, 16'h0000};
    run_packet("zeros", 0, 0);
    pkt = '{16'h0000, 16'h8000};
    run_packet("zeros_rev", 0, 0);
    pkt = '{16'hFC00, 16'h7C00};
    run_packet("infs", 0, 0);
    pkt = '{16'h7E00, 16'h3C00, 16'h7C01};
    run_packet("nan_mix", 0, 0);
    pkt = '{16'h7E00};
    run_packet("all_nan", 0, 0);
    pkt = '{16'h7C01, 16'hFE00};
    run_packet("all_nan_snan", 0, 1);
  endtask

  task automatic test_hold_stall();
    pkt = '{16'hC500, 16'h3800, 16'hBC00};
    run_packet("stall", 5, 0);
    pkt = '{16'h4200};
    run_packet("after_stall", 0, 0);
  endtask

  task automatic test_saturation();
    pkt = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
    run_packet("sat5", 0, 0);
    pkt = {};
    for (int i = 0; i < 300; i++) pkt.push_back(16'(i * 37));
    pkt[299] = 16'hFBFF;
    run_packet("sat300", 1, 0);
  endtask

  task automatic test_mid_reset();
    in_valid = 1;
    in_last = 0;
    in_data = 16'h4000;
    @(posedge clk); #1;
    in_data = 16'hC400;
    @(posedge clk); #1;
    in_valid = 0;
    rst_n = 0;
    #2;
    checks++;
    if (out_valid !== 0 || out_min !== 0 || out_max !== 0 || out_count !== 0 || out_nan !== 0 || out_snan !== 0 || out_allnan !== 0) begin
      errors++;
      $display("FAIL mid_reset_outputs: v=%b min=%h max=%h cnt=%0d; need all 0", out_valid, out_min, out_max, out_count);
    end
    #2;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_count !== 8'd0) begin
        errors++;
        $display("FAIL mid_reset_quiet cyc%0d: v=%b cnt=%0d need 0/0", i, out_valid, out_count);
      end
    end
    pkt = '{16'h3C00};
    run_packet("post_reset", 0, 0);
  endtask

  task automatic test_back_to_back();
    int cat;
    logic [15:0] h;
    for (int p = 0; p < 40; p++) begin
      pkt = {};
      for (int b = 0; b < int'($urandom_range(1, 8)); b++) begin
        cat = int'($urandom_range(0, 9));
        h = 16'($urandom);
        case (cat)
          0: h = {h[15], 5'h1f, 1'b1, h[8:0]};
          1: h = {h[15], 5'h1f, 1'b0, h[8:1], 1'b1};
          2: h = {h[15], 15'h0};
          3: h = {h[15], 15'h7C00};
          4: if (pkt.size() > 0) h = pkt[0];
          default: ;
        endcase
        pkt.push_back(h);
      end
      run_packet($sformatf("rand%0d", p), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_stall();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
